// File: rtl/swpd_serial_scheduler.sv
// Round-robin scheduler that shares one Serial MCU link between NUM_REQ requesters.
// Each accepted command gets exactly one response; failed transfers are retried and hung links time out.
module swpd_serial_scheduler #(
   parameter int NUM_REQ        = 4,
   parameter int MAX_RETRY      = 2,
   parameter int TIMEOUT_CYCLES = 65535
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_REQ-1:0]         req_valid,
   input  logic [8*NUM_REQ-1:0]       req_cmd,
   input  logic [2*NUM_REQ-1:0]       req_reply_len,
   output logic [NUM_REQ-1:0]         req_ready,
   output logic                       resp_valid,
   output logic [$clog2(NUM_REQ)-1:0] resp_id,
   output logic [13:0]                resp_data,
   output logic                       resp_error,
   output logic                       resp_timeout,
   output logic [1:0]                 resp_retries,
   output logic                       ser_enable,
   input  logic                       ser_transfer_running,
   output logic [1:0]                 ser_reply_len,
   output logic [7:0]                 ser_send_data,
   output logic                       ser_transfer_request,
   input  logic                       ser_transfer_done,
   input  logic [13:0]                ser_receive_data,
   input  logic                       ser_transfer_error,
   output logic [2:0]                 dbg_state
);
   localparam int IW = $clog2(NUM_REQ);
   localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ISSUE = 3'd1,
      S_BUSY  = 3'd2,
      S_RESP  = 3'd3,
      S_FLUSH = 3'd4
   } state_t;

   state_t        state;
   logic [IW-1:0] last_grant;
   logic [IW-1:0] cur_id;
   logic [RW-1:0] retry_cnt;
   logic [TW-1:0] timer;

   logic          grant_found;
   logic [IW-1:0] grant_idx;
   logic          arb_go;
   logic [7:0]    sel_cmd;
   logic [1:0]    sel_len;
   logic [31:0]   retry_ext;
   logic [1:0]    sat_retries;

   assign dbg_state = state;

   // Search starts one past the last winner so every requester gets a turn.
   always_comb begin
      int cand;
      cand        = 0;
      grant_found = 1'b0;
      grant_idx   = '0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         cand = (int'(last_grant) + i) % NUM_REQ;
         if (!grant_found && req_valid[IW'(cand)]) begin
            grant_found = 1'b1;
            grant_idx   = IW'(cand);
         end
      end
   end

   assign arb_go = (state == S_IDLE) && ser_enable && !ser_transfer_running && grant_found;

   always_comb begin
      req_ready = '0;
      if (arb_go) req_ready[grant_idx] = 1'b1;
   end

   always_comb begin
      sel_cmd = '0;
      sel_len = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant_idx == IW'(i)) begin
            sel_cmd = req_cmd[i*8 +: 8];
            sel_len = req_reply_len[i*2 +: 2];
         end
      end
   end

   always_comb begin
      retry_ext   = 32'(retry_cnt);
      sat_retries = (retry_ext > 32'd3) ? 2'd3 : retry_ext[1:0];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state                <= S_IDLE;
         last_grant           <= IW'(NUM_REQ - 1);
         cur_id               <= '0;
         retry_cnt            <= '0;
         timer                <= '0;
         ser_enable           <= 1'b0;
         ser_send_data        <= '0;
         ser_reply_len        <= '0;
         ser_transfer_request <= 1'b0;
         resp_valid           <= 1'b0;
         resp_id              <= '0;
         resp_data            <= '0;
         resp_error           <= 1'b0;
         resp_timeout         <= 1'b0;
         resp_retries         <= '0;
      end else begin
         ser_enable           <= 1'b1;
         ser_transfer_request <= 1'b0;
         resp_valid           <= 1'b0;
         case (state)
            S_IDLE: begin
               if (arb_go) begin
                  ser_send_data        <= sel_cmd;
                  ser_reply_len        <= sel_len;
                  cur_id               <= grant_idx;
                  last_grant           <= grant_idx;
                  retry_cnt            <= '0;
                  ser_transfer_request <= 1'b1;
                  state                <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               timer <= '0;
               state <= S_BUSY;
            end
            S_BUSY: begin
               timer <= timer + TW'(1);
               // A completion on the last allowed cycle still counts as a completion.
               if (ser_transfer_done) begin
                  if (ser_transfer_error && (retry_cnt < RW'(MAX_RETRY))) begin
                     retry_cnt            <= retry_cnt + RW'(1);
                     ser_transfer_request <= 1'b1;
                     state                <= S_ISSUE;
                  end else begin
                     resp_valid   <= 1'b1;
                     resp_id      <= cur_id;
                     resp_data    <= ser_receive_data;
                     resp_error   <= ser_transfer_error;
                     resp_timeout <= 1'b0;
                     resp_retries <= sat_retries;
                     state        <= S_RESP;
                  end
               end else if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
                  state <= S_FLUSH;
               end
            end
            S_FLUSH: begin
               // Serial must go quiet before the link is reused; stray completions are dropped.
               if (!ser_transfer_running) begin
                  resp_valid   <= 1'b1;
                  resp_id      <= cur_id;
                  resp_data    <= '0;
                  resp_error   <= 1'b1;
                  resp_timeout <= 1'b1;
                  resp_retries <= sat_retries;
                  state        <= S_RESP;
               end
            end
            S_RESP: state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_swpd_serial_scheduler.sv
// Directed bench for swpd_serial_scheduler: a hand-driven Serial model and fixed expected values.
module tb_swpd_serial_scheduler;
   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_ISSUE = 3'd1;
   localparam logic [2:0] ST_BUSY  = 3'd2;
   localparam logic [2:0] ST_FLUSH = 3'd4;

   logic        clk;
   logic        rst;
   logic [3:0]  req_valid;
   logic [31:0] req_cmd;
   logic [7:0]  req_reply_len;
   logic [3:0]  req_ready;
   logic        resp_valid;
   logic [1:0]  resp_id;
   logic [13:0] resp_data;
   logic        resp_error;
   logic        resp_timeout;
   logic [1:0]  resp_retries;
   logic        ser_enable;
   logic        ser_transfer_running;
   logic [1:0]  ser_reply_len;
   logic [7:0]  ser_send_data;
   logic        ser_transfer_request;
   logic        ser_transfer_done;
   logic [13:0] ser_receive_data;
   logic        ser_transfer_error;
   logic [2:0]  dbg_state;

   int vec_cnt;
   int err_cnt;
   logic [3:0] exp_q[$];

   swpd_serial_scheduler #(.NUM_REQ(4), .MAX_RETRY(2), .TIMEOUT_CYCLES(16)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_cmd(req_cmd), .req_reply_len(req_reply_len), .req_ready(req_ready),
      .resp_valid(resp_valid), .resp_id(resp_id), .resp_data(resp_data), .resp_error(resp_error),
      .resp_timeout(resp_timeout), .resp_retries(resp_retries),
      .ser_enable(ser_enable), .ser_transfer_running(ser_transfer_running), .ser_reply_len(ser_reply_len),
      .ser_send_data(ser_send_data), .ser_transfer_request(ser_transfer_request),
      .ser_transfer_done(ser_transfer_done), .ser_receive_data(ser_receive_data),
      .ser_transfer_error(ser_transfer_error), .dbg_state(dbg_state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // driver tasks
   task automatic wait_grant(output logic [3:0] rdy, output int n);
      rdy = '0;
      n   = 0;
      for (int k = 0; k < 40; k++) begin
         #1;
         if (req_ready !== 4'b0000) begin
            rdy = req_ready;
            break;
         end
         @(negedge clk);
         n++;
      end
   endtask

   task automatic drive_done(input logic [13:0] data, input logic err);
      ser_transfer_done  = 1'b1;
      ser_transfer_error = err;
      ser_receive_data   = data;
      @(negedge clk);
      ser_transfer_done  = 1'b0;
      ser_transfer_error = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      vec_cnt++;
      if (ser_enable !== 1'b0) begin err_cnt++; $display("FAIL reset_enable got %b exp 0", ser_enable); end
      vec_cnt++;
      if (dbg_state !== ST_IDLE) begin err_cnt++; $display("FAIL reset_state got %0d exp 0", dbg_state); end
      vec_cnt++;
      if ({resp_valid, ser_transfer_request, ser_send_data, ser_reply_len, resp_data} !== '0) begin
         err_cnt++; $display("FAIL reset_outputs got nonzero outputs");
      end
      rst = 1'b0;
      @(negedge clk);
      vec_cnt++;
      if (ser_enable !== 1'b1) begin err_cnt++; $display("FAIL enable_after_reset got %b exp 1", ser_enable); end
   endtask

   task automatic test_single();
      req_cmd[7:0]       = 8'h5A;
      req_reply_len[1:0] = 2'd2;
      req_valid          = 4'b0001;
      #1;
      vec_cnt++;
      if (req_ready !== 4'b0001) begin err_cnt++; $display("FAIL single_ready got %b exp 0001", req_ready); end
      @(negedge clk);
      vec_cnt++;
      if ({ser_transfer_request, ser_send_data, ser_reply_len} !== {1'b1, 8'h5A, 2'd2}) begin
         err_cnt++; $display("FAIL single_issue got req=%b cmd=%h len=%0d exp 1 5a 2",
                             ser_transfer_request, ser_send_data, ser_reply_len);
      end
      req_valid = 4'b0000;
      @(negedge clk);
      vec_cnt++;
      if (ser_transfer_request !== 1'b0) begin err_cnt++; $display("FAIL single_req_pulse got %b exp 0", ser_transfer_request); end
      drive_done(14'h1234, 1'b0);
      vec_cnt++;
      if ({resp_valid, resp_id, resp_data, resp_error, resp_timeout, resp_retries} !==
          {1'b1, 2'd0, 14'h1234, 1'b0, 1'b0, 2'd0}) begin
         err_cnt++; $display("FAIL single_resp got v=%b id=%0d d=%h e=%b t=%b r=%0d exp 1 0 1234 0 0 0",
                             resp_valid, resp_id, resp_data, resp_error, resp_timeout, resp_retries);
      end
      @(negedge clk);
      vec_cnt++;
      if ({resp_valid, ser_send_data} !== {1'b0, 8'h5A}) begin
         err_cnt++; $display("FAIL single_after got v=%b cmd=%h exp 0 5a", resp_valid, ser_send_data);
      end
   endtask

   task automatic test_round_robin();
      logic [3:0] rdy;
      logic [3:0] exp;
      int n;
      int gap;
      exp_q = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      req_cmd       = {8'h13, 8'h12, 8'h11, 8'h10};
      req_reply_len = 8'b01_01_01_01;
      req_valid     = 4'b1111;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      gap = 2;
      for (int g = 0; g < 5; g++) begin
         exp = exp_q.pop_front();
         wait_grant(rdy, n);
         vec_cnt++;
         if (rdy !== exp) begin err_cnt++; $display("FAIL rr_grant%0d got %b exp %b", g, rdy, exp); end
         vec_cnt++;
         if (gap + n < 2) begin err_cnt++; $display("FAIL rr_gap%0d got %0d exp >=2", g, gap + n); end
         @(negedge clk);
         if (g == 4) req_valid = 4'b0000;
         vec_cnt++;
         if (ser_send_data !== (8'h10 + 8'(g % 4))) begin
            err_cnt++; $display("FAIL rr_cmd%0d got %h exp %h", g, ser_send_data, 8'h10 + 8'(g % 4));
         end
         @(negedge clk);
         drive_done(14'(16 + g), 1'b0);
         vec_cnt++;
         if ({resp_valid, resp_id} !== {1'b1, 2'(g % 4)}) begin
            err_cnt++; $display("FAIL rr_resp%0d got v=%b id=%0d exp 1 %0d", g, resp_valid, resp_id, g % 4);
         end
         gap = 1;
      end
      @(negedge clk);
   endtask

   task automatic test_retry(input int nerr, input logic [13:0] fin_data);
      logic err;
      req_cmd[23:16]     = 8'hA5;
      req_reply_len[5:4] = 2'd3;
      req_valid          = 4'b0100;
      #1;
      vec_cnt++;
      if (req_ready !== 4'b0100) begin err_cnt++; $display("FAIL retry%0d_ready got %b exp 0100", nerr, req_ready); end
      @(negedge clk);
      req_valid = 4'b0000;
      for (int a = 0; a < 3; a++) begin
         vec_cnt++;
         if ({ser_transfer_request, ser_send_data} !== {1'b1, 8'hA5}) begin
            err_cnt++; $display("FAIL retry%0d_req%0d got req=%b cmd=%h exp 1 a5", nerr, a, ser_transfer_request, ser_send_data);
         end
         @(negedge clk);
         err = (a < nerr);
         drive_done((a == 2) ? fin_data : 14'h0001, err);
         if (!err) break;
      end
      vec_cnt++;
      if ({resp_valid, resp_id, resp_data, resp_error, resp_timeout, resp_retries, ser_transfer_request} !==
          {1'b1, 2'd2, fin_data, (nerr > 2), 1'b0, 2'd2, 1'b0}) begin
         err_cnt++; $display("FAIL retry%0d_resp got v=%b id=%0d d=%h e=%b t=%b r=%0d req=%b exp 1 2 %h %b 0 2 0",
                             nerr, resp_valid, resp_id, resp_data, resp_error, resp_timeout, resp_retries,
                             ser_transfer_request, fin_data, (nerr > 2));
      end
      @(negedge clk);
   endtask

   task automatic test_timeout();
      req_cmd[15:8] = 8'h33;
      req_valid     = 4'b0010;
      #1;
      vec_cnt++;
      if (req_ready !== 4'b0010) begin err_cnt++; $display("FAIL tmo_ready got %b exp 0010", req_ready); end
      @(negedge clk);
      req_valid = 4'b0000;
      ser_transfer_running = 1'b1;
      repeat (16) @(negedge clk);
      vec_cnt++;
      if (dbg_state !== ST_BUSY) begin err_cnt++; $display("FAIL tmo_last_busy got %0d exp 2", dbg_state); end
      @(negedge clk);
      drive_done(14'h1111, 1'b0);
      for (int k = 0; k < 4; k++) begin
         vec_cnt++;
         if ({dbg_state, resp_valid} !== {ST_FLUSH, 1'b0}) begin
            err_cnt++; $display("FAIL tmo_flush%0d got st=%0d v=%b exp 4 0", k, dbg_state, resp_valid);
         end
         @(negedge clk);
      end
      ser_transfer_running = 1'b0;
      @(negedge clk);
      vec_cnt++;
      if ({resp_valid, resp_id, resp_data, resp_error, resp_timeout, resp_retries} !==
          {1'b1, 2'd1, 14'h0000, 1'b1, 1'b1, 2'd0}) begin
         err_cnt++; $display("FAIL tmo_resp got v=%b id=%0d d=%h e=%b t=%b r=%0d exp 1 1 0000 1 1 0",
                             resp_valid, resp_id, resp_data, resp_error, resp_timeout, resp_retries);
      end
      @(negedge clk);
   endtask

   task automatic test_done_at_timeout();
      req_cmd[31:24] = 8'h44;
      req_valid      = 4'b1000;
      #1;
      vec_cnt++;
      if (req_ready !== 4'b1000) begin err_cnt++; $display("FAIL edge_ready got %b exp 1000", req_ready); end
      @(negedge clk);
      req_valid = 4'b0000;
      repeat (16) @(negedge clk);
      vec_cnt++;
      if (dbg_state !== ST_BUSY) begin err_cnt++; $display("FAIL edge_busy got %0d exp 2", dbg_state); end
      drive_done(14'h3ABC, 1'b0);
      vec_cnt++;
      if ({resp_valid, resp_id, resp_data, resp_error, resp_timeout} !== {1'b1, 2'd3, 14'h3ABC, 1'b0, 1'b0}) begin
         err_cnt++; $display("FAIL edge_resp got v=%b id=%0d d=%h e=%b t=%b exp 1 3 3abc 0 0",
                             resp_valid, resp_id, resp_data, resp_error, resp_timeout);
      end
      @(negedge clk);
   endtask

   task automatic test_reset_midflight();
      logic [3:0] rdy;
      int n;
      int seen;
      seen = 0;
      req_cmd[7:0] = 8'h77;
      req_valid    = 4'b0001;
      #1;
      vec_cnt++;
      if (req_ready !== 4'b0001) begin err_cnt++; $display("FAIL mid_ready got %b exp 0001", req_ready); end
      @(negedge clk);
      @(negedge clk);
      vec_cnt++;
      if (dbg_state !== ST_BUSY) begin err_cnt++; $display("FAIL mid_busy got %0d exp 2", dbg_state); end
      rst = 1'b1;
      req_valid = 4'b1111;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         if (resp_valid === 1'b1) seen++;
         vec_cnt++;
         if ({ser_enable, dbg_state, ser_send_data, ser_transfer_request} !== {1'b0, ST_IDLE, 8'h00, 1'b0}) begin
            err_cnt++; $display("FAIL mid_in_reset%0d got en=%b st=%0d cmd=%h req=%b exp 0 0 00 0",
                                k, ser_enable, dbg_state, ser_send_data, ser_transfer_request);
         end
      end
      rst = 1'b0;
      wait_grant(rdy, n);
      vec_cnt++;
      if (rdy !== 4'b0001) begin err_cnt++; $display("FAIL mid_restart got %b exp 0001", rdy); end
      req_valid = 4'b0000;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         if (resp_valid === 1'b1) seen++;
      end
      vec_cnt++;
      if (seen != 0) begin err_cnt++; $display("FAIL mid_no_resp got %0d strobes exp 0", seen); end
   endtask

   initial begin
      vec_cnt = 0;
      err_cnt = 0;
      rst = 1'b1;
      req_valid = '0;
      req_cmd = '0;
      req_reply_len = '0;
      ser_transfer_running = 1'b0;
      ser_transfer_done = 1'b0;
      ser_transfer_error = 1'b0;
      ser_receive_data = '0;
      @(negedge clk);
      test_reset();
      test_single();
      test_round_robin();
      test_retry(2, 14'h2AAA);
      test_retry(3, 14'h0F0F);
      test_timeout();
      test_done_at_timeout();
      test_reset_midflight();
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end
endmodule
